// File: rtl/rom_loader_pkg.sv
// Shared types for the ROM boot loader: FSM state encoding and length-header size.
package rom_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        DATA,
        WRITE,
        CSUM,
        DONE,
        ERR
    } rom_loader_state_e;

    localparam int unsigned LenBytes = 4;

endpackage

// File: rtl/rom_loader_byte_packer.sv
// Little-endian byte-to-word packer: first byte pushed lands in the least significant byte.
module byte_packer #(
    parameter int unsigned DataW = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clr,
    input  logic             i_push,
    input  logic [7:0]       i_byte,
    output logic             o_last,
    output logic             o_full,
    output logic [DataW-1:0] o_word
);

    localparam int unsigned Bpw  = DataW / 8;
    localparam int unsigned CntW = $clog2(Bpw + 1);

    logic [DataW-1:0] word_q, word_d;
    logic [CntW-1:0]  cnt_q, cnt_d;

    assign o_full = (cnt_q == CntW'(Bpw));
    assign o_last = (cnt_q == CntW'(Bpw - 1));
    assign o_word = word_q;

    always_comb begin
        word_d = word_q;
        cnt_d  = cnt_q;
        if (i_clr) begin
            word_d = '0;
            cnt_d  = '0;
        end else if (i_push && !o_full) begin
            // Shift right so each new byte enters at the top; written this way it also holds for DataW == 8.
            word_d = (word_q >> 8) | (DataW'(i_byte) << (DataW - 8));
            cnt_d  = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            word_q <= '0;
            cnt_q  <= '0;
        end else begin
            word_q <= word_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/rom_loader.sv
// Boot loader: receives a length-prefixed little-endian image and writes it into the instruction ROM.
// Optional trailing 8-bit checksum byte is enabled by defining ROM_LOADER_CHECKSUM_EN.
module rom_loader
    import rom_loader_pkg::*;
#(
    parameter int unsigned           MemAddrBus = 32,
    parameter int unsigned           MemDataBus = 32,
    parameter int unsigned           RomNum     = 4096,
    parameter logic [MemAddrBus-1:0] BaseAddr   = '0
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    input  logic                  i_rx_valid,
    input  logic [7:0]            i_rx_data,
    output logic                  o_rx_ready,
    output logic                  o_wen,
    output logic [MemAddrBus-1:0] o_waddr,
    output logic [MemDataBus-1:0] o_wdata,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_err,
    output logic                  o_core_rst_n
);

    localparam int unsigned BytesPerWord = MemDataBus / 8;
    localparam int unsigned IdxW         = $clog2(RomNum + 1);
    localparam int unsigned LcntW        = $clog2(LenBytes);
`ifdef ROM_LOADER_CHECKSUM_EN
    localparam rom_loader_state_e TailState = CSUM;
`else
    localparam rom_loader_state_e TailState = DONE;
`endif

    rom_loader_state_e state_q, state_d;

    logic [31:0]           len_q;
    logic [LcntW-1:0]      lcnt_q;
    logic [IdxW-1:0]       idx_q;
    logic                  rx_ready_q, rx_ready_d;
    logic                  wen_q, wen_d;
    logic [MemAddrBus-1:0] waddr_q, waddr_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic                  core_rst_n_q, core_rst_n_d;

    logic                  rx_fire;
    logic                  load_start;
    logic                  len_last;
    logic [31:0]           len_next;
    logic                  last_word;
    logic                  pk_last;
    logic                  pk_full;
    logic [MemDataBus-1:0] pk_word;

    assign rx_fire    = i_rx_valid & rx_ready_q;
    assign load_start = i_start & ((state_q == IDLE) | (state_q == DONE) | (state_q == ERR));
    assign len_last   = (lcnt_q == LcntW'(LenBytes - 1));
    assign len_next   = {i_rx_data, len_q[31:8]};
    assign last_word  = ((32'(idx_q) + 32'd1) == len_q);

`ifdef ROM_LOADER_CHECKSUM_EN
    logic [7:0] csum_q;
    logic       csum_ok;
    assign csum_ok = ((csum_q + i_rx_data) == 8'h00);
`endif

    // The packer is emptied both on a fresh load and once its full word has been written.
    byte_packer #(
        .DataW (MemDataBus)
    ) u_packer (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clr   (load_start | pk_full),
        .i_push  (rx_fire & (state_q == DATA)),
        .i_byte  (i_rx_data),
        .o_last  (pk_last),
        .o_full  (pk_full),
        .o_word  (pk_word)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (i_start) state_d = LEN;
            end
            LEN: begin
                if (rx_fire && len_last) begin
                    if (len_next == 32'd0)              state_d = TailState;
                    else if (len_next > 32'(RomNum))    state_d = ERR;
                    else                                state_d = DATA;
                end
            end
            DATA: begin
                if (rx_fire && pk_last) state_d = WRITE;
            end
            WRITE: begin
                state_d = last_word ? TailState : DATA;
            end
`ifdef ROM_LOADER_CHECKSUM_EN
            CSUM: begin
                if (rx_fire) state_d = csum_ok ? DONE : ERR;
            end
`endif
            DONE, ERR: begin
                if (i_start) state_d = LEN;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_comb begin
        rx_ready_d   = (state_d == LEN) | (state_d == DATA) | (state_d == CSUM);
        busy_d       = (state_d == LEN) | (state_d == DATA) | (state_d == WRITE) | (state_d == CSUM);
        wen_d        = (state_d == WRITE);
        done_d       = (state_d == DONE);
        err_d        = (state_d == ERR);
        core_rst_n_d = (state_d == DONE);
        waddr_d      = waddr_q;
        if (state_d == WRITE) begin
            waddr_d = BaseAddr + MemAddrBus'(idx_q) * MemAddrBus'(BytesPerWord);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rx_ready_q   <= 1'b0;
            wen_q        <= 1'b0;
            waddr_q      <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            core_rst_n_q <= 1'b0;
        end else begin
            rx_ready_q   <= rx_ready_d;
            wen_q        <= wen_d;
            waddr_q      <= waddr_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
            core_rst_n_q <= core_rst_n_d;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            len_q  <= '0;
            lcnt_q <= '0;
            idx_q  <= '0;
        end else if (load_start) begin
            len_q  <= '0;
            lcnt_q <= '0;
            idx_q  <= '0;
        end else begin
            if ((state_q == LEN) && rx_fire) begin
                len_q  <= len_next;
                lcnt_q <= lcnt_q + LcntW'(1);
            end
            if (state_q == WRITE) begin
                idx_q <= idx_q + IdxW'(1);
            end
        end
    end

`ifdef ROM_LOADER_CHECKSUM_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            csum_q <= 8'h00;
        end else if (load_start) begin
            csum_q <= 8'h00;
        end else if ((state_q == DATA) && rx_fire) begin
            csum_q <= csum_q + i_rx_data;
        end
    end
`endif

    assign o_rx_ready   = rx_ready_q;
    assign o_wen        = wen_q;
    assign o_waddr      = waddr_q;
    assign o_wdata      = pk_word;
    assign o_busy       = busy_q;
    assign o_done       = done_q;
    assign o_err        = err_q;
    assign o_core_rst_n = core_rst_n_q;

endmodule

// File: tb/tb_rom_loader.sv
// Self-checking bench for rom_loader: table-driven images, random images, reset and checksum corners.
module tb_rom_loader;

    localparam int unsigned RomNum = 4096;

    logic        clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_start = 1'b0;
    logic        i_rx_valid = 1'b0;
    logic [7:0]  i_rx_data = 8'h00;
    logic        o_rx_ready, o_wen, o_busy, o_done, o_err, o_core_rst_n;
    logic [31:0] o_waddr, o_wdata;

    always #5 clk = ~clk;

    rom_loader #(
        .MemAddrBus (32),
        .MemDataBus (32),
        .RomNum     (RomNum),
        .BaseAddr   (32'h0)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (i_rst_n),
        .i_start      (i_start),
        .i_rx_valid   (i_rx_valid),
        .i_rx_data    (i_rx_data),
        .o_rx_ready   (o_rx_ready),
        .o_wen        (o_wen),
        .o_waddr      (o_waddr),
        .o_wdata      (o_wdata),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_err        (o_err),
        .o_core_rst_n (o_core_rst_n)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] img_q[$];
    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    logic        prev_wen = 1'b0;

    typedef struct {
        logic [31:0] n;
        logic [31:0] w0;
        logic [31:0] w1;
        bit          gaps;
        bit          noisy;
        bit          exp_err;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Capture every ROM write; a write must be a single-cycle pulse with the byte input held off.
    always @(negedge clk) begin
        if (o_wen) begin
            wr_addr_q.push_back(o_waddr);
            wr_data_q.push_back(o_wdata);
            chk("ready_low_in_write", o_rx_ready, 0);
            chk("wen_single_pulse", prev_wen, 0);
        end
        prev_wen = o_wen;
    end

    task automatic check_reset_values(input string tag);
        chk({tag, "_rx_ready"}, o_rx_ready, 0);
        chk({tag, "_wen"}, o_wen, 0);
        chk({tag, "_waddr"}, o_waddr, 0);
        chk({tag, "_wdata"}, o_wdata, 0);
        chk({tag, "_busy"}, o_busy, 0);
        chk({tag, "_done"}, o_done, 0);
        chk({tag, "_err"}, o_err, 0);
        chk({tag, "_core_rst_n"}, o_core_rst_n, 0);
    endtask

    // Called at a negedge; returns at the negedge right after the byte was accepted.
    task automatic send_byte(input logic [7:0] b, input bit gaps, input bit noisy);
        int n;
        if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
                i_rx_valid = 1'b0;
                i_start    = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
                @(negedge clk);
            end
        end
        i_rx_valid = 1'b1;
        i_rx_data  = b;
        i_start    = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
        n = 0;
        while (!o_rx_ready && n < 64) begin
            @(negedge clk);
            i_start = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
            n++;
        end
        if (n >= 64) chk("rx_ready_timeout", 0, 1);
        @(negedge clk);
        i_start = 1'b0;
    endtask

    // Loads one image from img_q (first n words) and checks the outcome against the model.
    task automatic run_image(input logic [31:0] n, input bit gaps, input bit noisy,
                             input logic [7:0] csum_adj, input bit exp_err);
        logic [7:0] sum;
        sum = 8'h00;
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        chk("start_busy", o_busy, 1);
        chk("start_rx_ready", o_rx_ready, 1);
        chk("start_done_clear", o_done, 0);
        chk("start_err_clear", o_err, 0);
        chk("start_core_rst", o_core_rst_n, 0);
        wr_addr_q.delete();
        wr_data_q.delete();
        for (int k = 0; k < 4; k++) send_byte(n[8*k +: 8], gaps, noisy);
        if (n > RomNum) begin
            i_rx_valid = 1'b0;
            chk("len_err", o_err, 1);
            chk("len_err_done", o_done, 0);
            chk("len_err_core_rst", o_core_rst_n, 0);
            chk("len_err_busy", o_busy, 0);
            chk("len_err_ready", o_rx_ready, 0);
            repeat (4) @(negedge clk);
            chk("len_err_no_writes", wr_addr_q.size(), 0);
            return;
        end
        for (int i = 0; i < int'(n); i++) begin
            for (int k = 0; k < 4; k++) begin
                sum = sum + img_q[i][8*k +: 8];
                send_byte(img_q[i][8*k +: 8], gaps, noisy);
            end
        end
`ifdef ROM_LOADER_CHECKSUM_EN
        send_byte((8'h00 - sum) + csum_adj, gaps, noisy);
        i_rx_valid = 1'b0;
`else
        i_rx_valid = 1'b0;
        if (n != 0) begin
            chk("wen_after_last_byte", o_wen, 1);
            @(negedge clk);
        end
`endif
        chk("end_done", o_done, !exp_err);
        chk("end_err", o_err, exp_err);
        chk("end_core_rst", o_core_rst_n, !exp_err);
        chk("end_busy", o_busy, 0);
        chk("end_ready", o_rx_ready, 0);
        chk("write_count", wr_addr_q.size(), n);
        for (int i = 0; i < int'(n) && i < wr_addr_q.size(); i++) begin
            chk("write_addr", wr_addr_q[i], 32'(4 * i));
            chk("write_data", wr_data_q[i], img_q[i]);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{n: 32'd2,          w0: 32'h0000_0013, w1: 32'hDEAD_BEEF, gaps: 1'b0, noisy: 1'b0, exp_err: 1'b0};
        vecs[1] = '{n: 32'h0000_1001,  w0: 32'h0,         w1: 32'h0,         gaps: 1'b0, noisy: 1'b0, exp_err: 1'b1};
        vecs[2] = '{n: 32'd2,          w0: 32'h1122_3344, w1: 32'h5566_7788, gaps: 1'b1, noisy: 1'b1, exp_err: 1'b0};
        vecs[3] = '{n: 32'd0,          w0: 32'h0,         w1: 32'h0,         gaps: 1'b0, noisy: 1'b0, exp_err: 1'b0};
        vecs[4] = '{n: 32'hFFFF_FFFF,  w0: 32'h0,         w1: 32'h0,         gaps: 1'b1, noisy: 1'b0, exp_err: 1'b1};
        vecs[5] = '{n: 32'd1,          w0: 32'hA5A5_A5A5, w1: 32'h0,         gaps: 1'b0, noisy: 1'b0, exp_err: 1'b0};
        vecs[6] = '{n: 32'd4096,       w0: 32'hCAFE_0001, w1: 32'hCAFE_0002, gaps: 1'b0, noisy: 1'b0, exp_err: 1'b0};

        repeat (3) @(negedge clk);
        check_reset_values("reset");
        i_rst_n = 1'b1;
        @(negedge clk);
        check_reset_values("idle");

        for (int v = 0; v < 7; v++) begin
            img_q.delete();
            img_q.push_back(vecs[v].w0);
            img_q.push_back(vecs[v].w1);
            while (img_q.size() < 4096) img_q.push_back($urandom);
            run_image(vecs[v].n, vecs[v].gaps, vecs[v].noisy, 8'h00, vecs[v].exp_err);
            repeat (2) @(negedge clk);
        end

        for (int r = 0; r < 6; r++) begin
            logic [31:0] n;
            n = 32'($urandom_range(1, 6));
            img_q.delete();
            for (int i = 0; i < int'(n); i++) img_q.push_back($urandom);
            run_image(n, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'h00, 1'b0);
        end

        // Abort a load after six bytes, then confirm a clean restart.
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        send_byte(8'h02, 1'b0, 1'b0);
        send_byte(8'h00, 1'b0, 1'b0);
        send_byte(8'h00, 1'b0, 1'b0);
        send_byte(8'h00, 1'b0, 1'b0);
        send_byte(8'h11, 1'b0, 1'b0);
        send_byte(8'h22, 1'b0, 1'b0);
        i_rx_valid = 1'b0;
        #2 i_rst_n = 1'b0;
        #1 check_reset_values("midload_reset");
        @(negedge clk);
        i_rst_n = 1'b1;
        @(negedge clk);
        img_q.delete();
        img_q.push_back(32'hA5A5_A5A5);
        run_image(32'd1, 1'b0, 1'b0, 8'h00, 1'b0);

`ifdef ROM_LOADER_CHECKSUM_EN
        img_q.delete();
        img_q.push_back(32'h0102_0304);
        run_image(32'd1, 1'b0, 1'b0, 8'h00, 1'b0);
        run_image(32'd1, 1'b0, 1'b0, 8'hFF, 1'b1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
